// File: rtl/am_mul_share_arb.sv
// am_mul_share_arb: round-robin sharing of one external combinational 8x8
// multiplier core among NREQ requesters. Stage 1 registers the granted
// operands onto the core inputs; stage 2 captures the product together with
// the index of the requester that issued it.
module am_mul_share_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [8*NREQ-1:0]     req_x,
  input  logic [8*NREQ-1:0]     req_y,
  output logic [7:0]            mul_x,
  output logic [7:0]            mul_y,
  input  logic [15:0]           mul_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_z,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  localparam int unsigned OPW = 8;
  localparam int unsigned PW  = 16;

  // Stage-1 state beyond the operand registers themselves.
  logic            s1_valid;
  logic [IDW-1:0]  s1_id;

  // Round-robin pointer: index of the most recently accepted requester.
  logic [IDW-1:0]  last_id;

  // Pipeline advance and arbitration results.
  logic            s2_load;
  logic            s1_load;
  logic [NREQ-1:0] grant;
  logic            any_req;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  cand;
  logic [OPW-1:0]  win_x;
  logic [OPW-1:0]  win_y;
  logic            s1_valid_nxt;
  logic            s2_valid_nxt;

  // Stage advance: stage 2 frees up when empty or drained this cycle;
  // stage 1 frees up when empty or moving into stage 2.
  always_comb begin
    s2_load = s1_valid & (~rsp_valid | rsp_ready);
    s1_load = ~s1_valid | s2_load;
  end

  // Rotating-priority search starting just after last_id, ending at last_id.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_id) + k) % NREQ);
      if (!any_req && req_valid[cand]) begin
        any_req     = 1'b1;
        win_id      = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_x = req_x[{win_id, 3'b000} +: OPW];
    win_y = req_y[{win_id, 3'b000} +: OPW];
  end

  // Accept only when stage 1 can load; nothing is accepted during reset.
  always_comb begin
    req_ready = grant & {NREQ{s1_load & ~rst}};
  end

  // Next occupancy of both stages, used for the registered busy flag.
  always_comb begin
    s1_valid_nxt = s1_load ? any_req : s1_valid;
    if (s2_load) begin
      s2_valid_nxt = 1'b1;
    end else if (rsp_ready) begin
      s2_valid_nxt = 1'b0;
    end else begin
      s2_valid_nxt = rsp_valid;
    end
  end

  // Stage 1: operand register and round-robin pointer update on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      mul_x    <= '0;
      mul_y    <= '0;
      last_id  <= IDW'(NREQ - 1);
    end else if (s1_load) begin
      if (any_req) begin
        s1_valid <= 1'b1;
        s1_id    <= win_id;
        mul_x    <= win_x;
        mul_y    <= win_y;
        last_id  <= win_id;
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: capture the core product, tagged with the issuing requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= '0;
    end else if (s2_load) begin
      rsp_valid <= 1'b1;
      rsp_z     <= PW'(mul_z);
      rsp_id    <= s1_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Busy flag registered from the next occupancy of both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= s1_valid_nxt | s2_valid_nxt;
    end
  end

endmodule

// File: tb/tb_am_mul_share_arb.sv
// Scoreboard bench for am_mul_share_arb with an external multiplier core
// model that can be switched between exact and approximate behaviour.
module tb_am_mul_share_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [8*NREQ-1:0]   req_x;
  logic [8*NREQ-1:0]   req_y;
  logic [7:0]          mul_x;
  logic [7:0]          mul_y;
  logic [15:0]         mul_z;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [15:0]         rsp_z;
  logic [IDW-1:0]      rsp_id;
  logic                busy;
  logic                approx_mode;

  typedef struct {
    logic [15:0]    z;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  am_mul_share_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: exact product, or product of operands with the 2 LSBs dropped.
  always_comb begin
    if (approx_mode)
      mul_z = 16'({mul_x[7:2], 2'b00}) * 16'({mul_y[7:2], 2'b00});
    else
      mul_z = 16'(mul_x) * 16'(mul_y);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: each completed response handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got z=%0d id=%0d expected none", rsp_z, rsp_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_z", 32'(rsp_z), 32'(e.z));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int c;
    logic [15:0] fair_z [NREQ];
    fair_z[0] = 16'd30; fair_z[1] = 16'd33; fair_z[2] = 16'd36; fair_z[3] = 16'd39;

    approx_mode = 1'b0;
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_x     = '0;
    req_y     = '0;

    // Reset with all requests raised.
    tick; tick;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_x", 32'(mul_x), 32'd0);
    chk("rst_mul_y", 32'(mul_y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_z", 32'(rsp_z), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    tick;

    // Single request from requester 2: 200*100.
    req_valid = 4'b0100;
    req_x[23:16] = 8'd200;
    req_y[23:16] = 8'd100;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0100);
    sb.push_back('{16'd20000, 2'd2});
    tick;
    req_valid = '0;
    chk("single_lat1", 32'(rsp_valid), 32'd0);
    tick;
    chk("single_lat2", 32'(rsp_valid), 32'd1);
    tick; tick;

    // Fairness after a fresh reset: x_i = 10+i, y = 3.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_x[8*i +: 8] = 8'(10 + i);
      req_y[8*i +: 8] = 8'd3;
    end
    req_valid = '1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      chk("fair_grant", 32'(req_ready), 32'(1) << (cyc % 4));
      sb.push_back('{fair_z[cyc % 4], IDW'(cyc % 4)});
      tick;
    end
    req_valid = '0;
    tick; tick; tick;

    // Backpressure stream from requester 1: x=k, y=3.
    k = 1;
    c = 0;
    req_y[15:8] = 8'd3;
    while (k <= 6 && c < 40) begin
      rsp_ready = !(c >= 2 && c < 7);
      req_valid = 4'b0010;
      req_x[15:8] = 8'(k);
      #1;
      if (c >= 2 && c < 7) begin
        chk("bp_ready", 32'(req_ready), 32'd0);
        chk("bp_hold_z", 32'(rsp_z), 32'd3);
      end
      if (req_ready[1]) begin
        sb.push_back('{16'(3 * k), 2'd1});
        k++;
      end
      c++;
      tick;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    if (k <= 6) chk("bp_timeout", 32'(k), 32'd7);
    tick; tick; tick;

    // Reset with both stages occupied; the two products must never appear.
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    req_x[31:24] = 8'd5; req_y[31:24] = 8'd5;
    req_x[15:8]  = 8'd7; req_y[15:8]  = 8'd7;
    #1;
    chk("mid_grant3", 32'(req_ready), 32'b1000);
    tick;
    #1;
    chk("mid_grant1", 32'(req_ready), 32'b0010);
    tick;
    #1;
    chk("mid_full_ready", 32'(req_ready), 32'd0);
    chk("mid_full_busy", 32'(busy), 32'd1);
    chk("mid_full_rsp", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    req_valid = '0;
    tick;
    rst = 1'b0;
    rsp_ready = 1'b1;
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    req_valid = '1;
    #1;
    chk("mid_rst_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    tick; tick; tick;

    // Approximate core: 255*255 -> 252*252 = 63504.
    approx_mode = 1'b1;
    req_valid = 4'b1000;
    req_x[31:24] = 8'd255;
    req_y[31:24] = 8'd255;
    #1;
    chk("approx_ready", 32'(req_ready), 32'b1000);
    sb.push_back('{16'd63504, 2'd3});
    tick;
    req_valid = '0;
    tick; tick; tick;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/am_mul_share_arb.md
# am_mul_share_arb

Round-robin arbiter and 2-stage pipeline that shares one combinational unsigned 8x8 approximate multiplier core among NREQ requesters. It grants one request per cycle and registers the operands onto the core inputs. It captures the core product into a response register tagged with the requester index. The block sits between requesting datapath units and a single multiplier core instance, which is connected externally through the mul_* ports.

## Interface
- NREQ, 4, number of requesters; legal 2..8
- IDW, $clog2(NREQ), requester-index width (derived; not overridden)
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_x  in  8*NREQ  packed multiplicands; requester i uses bits [8i+7:8i]
- req_y  in  8*NREQ  packed multipliers, same packing
- mul_x  out  8  registered operand driven to the multiplier core x
- mul_y  out  8  registered operand driven to the multiplier core y
- mul_z  in  16  combinational product returned by the core
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_z  out  16  product
- rsp_id  out  IDW  index of the requester that issued the product
- busy  out  1  s1_valid | s2_valid

## Operation
- **Stage 1 (operand register):** holds s1_valid, s1_id, mul_x, mul_y.
- **Stage 2 (response register):** holds rsp_valid (s2_valid), rsp_z, rsp_id.
- **Advance conditions:**
  - s2_load = s1_valid & (~rsp_valid | rsp_ready)
  - s1_load = ~s1_valid | s2_load
- **Arbitration:** round-robin pointer last_id.
  - Candidate order is last_id+1, last_id+2, … modulo NREQ, ending with last_id itself.
  - The first requester in that order with req_valid high is the winner (grant one-hot).
  - req_ready = grant & {NREQ{s1_load}}. Acceptance occurs when req_valid[i] & req_ready[i].
- **On acceptance:**
  - mul_x <= req_x[i], mul_y <= req_y[i], s1_id <= i, s1_valid <= 1, last_id <= i.
- **When s1_load and no request is pending:** s1_valid <= 0. mul_x and mul_y hold their values; they do not toggle needlessly.
- **On s2_load:** rsp_z <= mul_z, rsp_id <= s1_id, rsp_valid <= 1.
- **On rsp_valid & rsp_ready without s2_load:** rsp_valid <= 0. rsp_z and rsp_id hold.
- **Pointer:** last_id changes only on acceptance. An idle requester never blocks others.
- **Arithmetic:** the block never modifies mul_z. It passes the core result unchanged, whatever approximation the core applies.
- **Requester rules:** req_x and req_y must be stable while req_valid is high and unaccepted. The block tolerates violation and samples at acceptance.

## Timing
- **Reset (synchronous, rst high at a rising edge):**
  - s1_valid=0, rsp_valid=0, busy=0
  - mul_x=0, mul_y=0, rsp_z=0, rsp_id=0
  - last_id=NREQ-1, so requester 0 has first priority
  - While rst is high, req_ready=0.
- **Reset mid-operation:** any in-flight stage-1/stage-2 contents are discarded with no response emitted. Requesters must re-issue.
- **Latency:** acceptance at edge E0 → mul_x/mul_y valid after E0 → rsp_valid high after E1 (2 cycles from acceptance cycle to response cycle).
- **Throughput:** 1 product per cycle while rsp_ready=1 and any req_valid is high.
- **Backpressure:** with rsp_ready held low, at most 2 products are outstanding (stage 1 and stage 2). req_ready is then all 0 and rsp_z/rsp_id stay stable.
- **Simultaneous events:** rsp_ready rising in the same cycle as the stall clears allows stage-2 load, stage-1 load and a new acceptance all in that cycle.
- **Combinational paths:**
  - req_ready depends combinationally on req_valid and rsp_ready.
  - mul_z to rsp_z is a register input only; there is no combinational path from mul_z to any output.

## Test plan
- **Reset:** rst=1 for 2 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, mul_x=mul_y=0, busy=0. After release, the first grant goes to requester 0.
- **Single request:** bench core model mul_z=mul_x*mul_y; requester 2 sends x=200, y=100 → accepted in that cycle; 2 cycles later rsp_valid=1, rsp_z=20000, rsp_id=2.
- **Fairness:** all 4 req_valid held high, rsp_ready=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3. 8 responses on consecutive cycles with matching ids and products.
- **Backpressure:** stream from requester 1 (x=k, y=3, k=1..6) with rsp_ready=0 for 5 cycles mid-stream → req_ready=0 after 2 outstanding, rsp_z frozen. After release, all 6 products 3,6,…,18 arrive in order with no loss or duplication.
- **Reset mid-operation:** rst pulsed 1 cycle while stage 1 and stage 2 are both valid → next cycle rsp_valid=0 and busy=0. Those two products never appear; the next grant goes to requester 0.
- **Approximate core:** instantiate an approximate unsigned 8x8 core on mul_*; x=255, y=255 from requester 3 → rsp_z equals that core's output for (255,255) bit-exactly, rsp_id=3.
